// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame slave: frame geometry and FSM state encoding.
package spi_pkg;

  localparam int FRAME_BYTES   = 3;
  localparam int BITS_PER_BYTE = 8;
  localparam int STATE_W       = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_CMD  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA = 3'd2;
  localparam logic [STATE_W-1:0] ST_RESP = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-bit synchroniser with one extra registered stage for rise/fall detection.
module spi_in_sync #(
  parameter int               STAGES     = 2,
  parameter int               WIDTH      = 3,
  parameter logic [WIDTH-1:0] IDLE_LEVEL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [WIDTH-1:0] r_sync [STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [STAGES:0]  r_fill;
  logic             w_armed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= IDLE_LEVEL;
      r_prev <= IDLE_LEVEL;
      r_fill <= '0;
    end else begin
      r_sync[0] <= i_async;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[STAGES-1];
      r_fill <= {r_fill[STAGES-1:0], 1'b1};
    end
  end

  // Edges are masked until real input levels have reached r_prev, so a line
  // already active when reset releases does not look like a fresh transition.
  assign w_armed = r_fill[STAGES];
  assign o_level = r_sync[STAGES-1];
  assign o_rise  = {WIDTH{w_armed}} & r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = {WIDTH{w_armed}} & ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_frame.sv
// SPI mode-0 slave decoding command/data/response frames in the clk_12mhz domain.
module spi_slave_frame #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BYTES = spi_pkg::FRAME_BYTES
) (
  input  logic                        clk_12mhz,
  input  logic                        rst,
  input  logic                        spi_clk,
  input  logic                        spi_cs,
  input  logic                        spi_mosi,
  output logic                        spi_miso,
  output logic [7:0]                  cmd,
  output logic [7:0]                  wdata,
  output logic                        cmd_valid,
  output logic [7:0]                  rd_addr,
  input  logic [7:0]                  rd_data,
  output logic                        frame_err,
  output logic                        busy,
  output logic [spi_pkg::STATE_W-1:0] o_dbg_state
);
  import spi_pkg::*;

  localparam logic [7:0] LAST_RESP = 8'(FRAME_BYTES - 3);

  // Bit order: [0] SCLK, [1] CS, [2] MOSI; idle levels CS=1, SCLK=0, MOSI=0.
  logic [2:0] w_async, w_level, w_rise, w_fall;
  logic       w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_mosi;
  logic       w_unused;

  assign w_async = {spi_mosi, spi_cs, spi_clk};

  spi_in_sync #(
    .STAGES     (SYNC_STAGES),
    .WIDTH      (3),
    .IDLE_LEVEL (3'b010)
  ) u_sync (
    .i_clk   (clk_12mhz),
    .i_rst_n (rst),
    .i_async (w_async),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_sclk_rise = w_rise[0];
  assign w_sclk_fall = w_fall[0];
  assign w_cs_rise   = w_rise[1];
  assign w_cs_fall   = w_fall[1];
  assign w_mosi      = w_level[2];
  assign w_unused    = ^{w_level[0], w_rise[2], w_fall[2]};

  logic [STATE_W-1:0] r_state;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift, r_tx, r_cmd, r_wdata, r_rd_addr, r_resp_cnt;
  logic               r_cmd_valid, r_frame_err, r_miso;
  logic [7:0]         w_byte;
  logic               w_byte_done;

  assign w_byte      = {r_shift[6:0], w_mosi};
  assign w_byte_done = w_sclk_rise && (r_bit == 3'(BITS_PER_BYTE - 1));

  // cmd_valid is a single-cycle strobe with no back-pressure: cmd/wdata are
  // stable when it is high and stay put until the next successful byte load.
  always_ff @(posedge clk_12mhz or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_bit       <= '0;
      r_shift     <= '0;
      r_tx        <= '0;
      r_cmd       <= '0;
      r_wdata     <= '0;
      r_rd_addr   <= '0;
      r_resp_cnt  <= '0;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_miso      <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_cs_rise) begin
        r_state     <= ST_IDLE;
        r_frame_err <= (r_state == ST_CMD) || (r_state == ST_DATA);
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_cs_fall) begin
              r_state <= ST_CMD;
              r_bit   <= '0;
              r_shift <= '0;
              r_miso  <= 1'b0;
            end
          end
          ST_CMD, ST_DATA: begin
            if (w_sclk_rise) begin
              r_shift <= w_byte;
              r_bit   <= r_bit + 3'd1;
            end
            if (w_byte_done) begin
              if (r_state == ST_CMD) begin
                r_cmd     <= w_byte;
                r_rd_addr <= w_byte;
                r_state   <= ST_DATA;
              end else begin
                r_wdata     <= w_byte;
                r_cmd_valid <= 1'b1;
                r_resp_cnt  <= '0;
                r_state     <= ST_RESP;
              end
            end
          end
          ST_RESP: begin
            if (r_cmd_valid) begin
              r_tx   <= rd_data;
              r_miso <= 1'b0;
            end else begin
              // The first fall after byte 1 presents TX[7]; each later fall the next bit.
              if (w_sclk_fall) begin
                r_miso <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b0};
              end
              if (w_sclk_rise) r_bit <= r_bit + 3'd1;
              if (w_byte_done) begin
                r_resp_cnt <= r_resp_cnt + 8'd1;
                if (r_resp_cnt == LAST_RESP) r_state <= ST_DONE;
              end
            end
          end
          ST_DONE: ;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign spi_miso    = (r_state == ST_RESP) && r_miso;
  assign cmd         = r_cmd;
  assign wdata       = r_wdata;
  assign rd_addr     = r_rd_addr;
  assign cmd_valid   = r_cmd_valid;
  assign frame_err   = r_frame_err;
  assign busy        = ~w_level[1];
  assign o_dbg_state = r_state;

endmodule

// File: doc/spi_slave_frame.md
SPI_SLAVE_FRAME -- requirements
Module: spi_slave_frame

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops synchronising each SPI input into the clk_12mhz domain.
REQ-002 SHALL have parameter FRAME_BYTES, default 3, meaning the number of bytes in one frame: command, data, response.
REQ-003 SHALL have port clk_12mhz, input, 1 bit: system clock; the block's only clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port spi_clk, input, 1 bit: SPI SCLK, mode 0, idle low, asynchronous to clk_12mhz.
REQ-006 SHALL have port spi_cs, input, 1 bit: active-low chip select, asynchronous.
REQ-007 SHALL have port spi_mosi, input, 1 bit: master data, sampled on SCLK rise, MSB first.
REQ-008 SHALL have port spi_miso, output, 1 bit: slave data, changes on SCLK fall, MSB first.
REQ-009 SHALL have port cmd, output, 8 bits: byte 0 of the last frame.
REQ-010 SHALL have port wdata, output, 8 bits: byte 1 of the last frame.
REQ-011 SHALL have port cmd_valid, output, 1 bit: one-cycle strobe when cmd/wdata are complete.
REQ-012 SHALL have port rd_addr, output, 8 bits: byte 0, presented for register lookup.
REQ-013 SHALL have port rd_data, input, 8 bits: response value, returned in byte 2.
REQ-014 SHALL have port frame_err, output, 1 bit: one-cycle strobe when CS deasserts before byte 1 completes.
REQ-015 SHALL have port busy, output, 1 bit: high while CS is asserted, as seen after synchronisation.

Function
REQ-016 SHALL pass spi_clk, spi_cs and spi_mosi through SYNC_STAGES flops, then detect SCLK rise/fall and CS fall/rise with one further registered stage.
REQ-017 SHALL support SCLK half-period >= 3 clk_12mhz cycles (250 ns); faster SCLK is unsupported.
REQ-018 SHALL implement FSM IDLE -> CMD -> DATA -> RESP -> DONE.
REQ-019 SHALL leave IDLE for CMD on detected CS fall, clearing the bit counter (3 bits) and the shift register.
REQ-020 SHALL, on each detected SCLK rise in CMD/DATA, shift mosi into bit 0 and increment the bit counter.
REQ-021 SHALL, on the 8th rise in CMD, load cmd and rd_addr with the assembled byte and enter DATA.
REQ-022 SHALL, on the 8th rise in DATA, load wdata, pulse cmd_valid on the following cycle and enter RESP.
REQ-023 SHALL capture rd_data into the TX shift register on the cycle cmd_valid pulses (rd_data must be valid within 1 cycle of rd_addr update, or by that cycle).
REQ-024 SHALL, in RESP, drive spi_miso = TX[7] from the first detected SCLK fall after byte 1, then shift left on each subsequent fall.
REQ-025 SHALL enter DONE after the 8th rise in RESP; further SCLK edges SHALL be ignored and spi_miso SHALL be 0.
REQ-026 SHALL hold spi_miso = 0 in IDLE, CMD, DATA and DONE.
REQ-027 SHALL, on detected CS rise in any state, return to IDLE the same cycle.
REQ-028 SHALL pulse frame_err on detected CS rise if the state is CMD or DATA, with no cmd_valid for that frame.
REQ-029 SHALL give priority to a CS rise when it coincides with an SCLK edge in the same cycle; the edge is discarded.
REQ-030 SHALL hold cmd, wdata and rd_addr until the next successful byte load.

Reset
REQ-031 SHALL, while rst = 0, force: state IDLE; cmd, wdata and rd_addr 8'h00; cmd_valid, frame_err and busy 0; spi_miso 0; synchroniser flops to idle levels (CS 1, SCLK 0, MOSI 0).
REQ-032 SHALL, after reset release mid-frame with CS low, stay in IDLE until a fresh CS fall.

Structure
REQ-033 SHALL take the state encoding, FRAME_BYTES and BITS_PER_BYTE = 8 from shared package spi_pkg.
REQ-034 SHALL put the synchroniser and edge detector in sub-module spi_in_sync, instantiated once for three signals.
REQ-035 SHALL keep the implementation at 120-400 lines of RTL.

Verification
REQ-036 SHALL test a frame 0x01, 0x11, xx at 2 MHz -> one cmd_valid, cmd = 8'h01, wdata = 8'h11, frame_err never high.
REQ-037 SHALL test rd_data = 8'hA5 -> MISO bits during byte 2 are 1,0,1,0,0,1,0,1; MISO is 0 during bytes 0-1.
REQ-038 SHALL test CS rising after 5 SCLK of byte 1 -> frame_err pulses once, no cmd_valid, cmd keeps its previous value.
REQ-039 SHALL test 16 back-to-back frames, byte 1 = 8'h11..8'h20, with a 4 us CS-high gap -> 16 cmd_valid pulses with matching wdata, in order.
REQ-040 SHALL test rst low at bit 12, released with CS still low -> all outputs at reset values, no strobe until the next CS fall; the next frame decodes correctly.
REQ-041 SHALL test 30 SCLK pulses in one frame -> exactly one cmd_valid; MISO is 0 after bit 24.
